// File: rtl/zube_bus_sequencer_if.sv
// Requester handshakes plus the zube peripheral bus, as seen by the sequencer.
// The master modport is the sequencer; slave is the requester/peripheral side.
interface zube_bus_sequencer_if;
   logic        req0, we0, done0;
   logic [15:0] addr0;
   logic [7:0]  wdata0;
   logic        req1, we1, done1;
   logic [15:0] addr1;
   logic [7:0]  wdata1;
   logic [7:0]  rdata;
   logic        busy;
   logic [15:0] address_bus;
   logic [7:0]  data_bus_out;
   logic [7:0]  data_bus_in;
   logic        write_strobe_b;
   logic        read_strobe_b;

   modport master (
      input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, data_bus_in,
      output done0, done1, rdata, busy, address_bus, data_bus_out,
             write_strobe_b, read_strobe_b
   );

   modport slave (
      output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, data_bus_in,
      input  done0, done1, rdata, busy, address_bus, data_bus_out,
             write_strobe_b, read_strobe_b
   );
endinterface

// File: rtl/zube_bus_sequencer.sv
// Round-robin bus master: turns single-byte requests from two requesters into
// timed setup/strobe/hold cycles on the zube peripheral bus.
module zube_bus_sequencer #(
   parameter int SETUP_CYCLES  = 1,
   parameter int STROBE_CYCLES = 4,
   parameter int HOLD_CYCLES   = 1
) (
   input  logic                 clk,
   input  logic                 reset_b,
   zube_bus_sequencer_if.master bus
);
   typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

   localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYCLES - 1);
   localparam logic [3:0] STROBE_LD = 4'(STROBE_CYCLES - 1);
   localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYCLES - 1);

   state_t      state, state_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic        last_grant, last_grant_nxt;
   logic        gnt, gnt_nxt;
   logic        cyc_we, cyc_we_nxt;
   logic        pick;
   logic [1:0]  req, done, done_nxt;
   logic [15:0] addr_q, addr_nxt;
   logic [7:0]  dout_q, dout_nxt, rdata_q, rdata_nxt;
   logic        wstb_b, wstb_b_nxt, rstb_b, rstb_b_nxt;
   logic        busy_q, busy_nxt;

   assign req  = {bus.req1, bus.req0};
   // on a tie, serve the requester that was not served last
   assign pick = (&req) ? ~last_grant : req[1];

   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      last_grant_nxt = last_grant;
      gnt_nxt        = gnt;
      cyc_we_nxt     = cyc_we;
      addr_nxt       = addr_q;
      dout_nxt       = dout_q;
      rdata_nxt      = rdata_q;
      wstb_b_nxt     = wstb_b;
      rstb_b_nxt     = rstb_b;
      done_nxt       = 2'b00;
      case (state)
         IDLE: if (|req) begin
            gnt_nxt        = pick;
            last_grant_nxt = pick;
            addr_nxt       = pick ? bus.addr1  : bus.addr0;
            dout_nxt       = pick ? bus.wdata1 : bus.wdata0;
            cyc_we_nxt     = pick ? bus.we1    : bus.we0;
            cnt_nxt        = SETUP_LD;
            state_nxt      = SETUP;
         end
         SETUP: if (cnt == 4'd0) begin
            wstb_b_nxt = ~cyc_we;
            rstb_b_nxt = cyc_we;
            cnt_nxt    = STROBE_LD;
            state_nxt  = STROBE;
         end else cnt_nxt = cnt - 4'd1;
         STROBE: if (cnt == 4'd0) begin
            if (!cyc_we) rdata_nxt = bus.data_bus_in;
            wstb_b_nxt = 1'b1;
            rstb_b_nxt = 1'b1;
            cnt_nxt    = HOLD_LD;
            state_nxt  = HOLD;
         end else cnt_nxt = cnt - 4'd1;
         HOLD: if (cnt == 4'd0) begin
            done_nxt[gnt] = 1'b1;
            state_nxt     = DONE;
         end else cnt_nxt = cnt - 4'd1;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      busy_nxt = (state_nxt != IDLE);
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         last_grant <= 1'b1;
         gnt        <= 1'b0;
         cyc_we     <= 1'b0;
         addr_q     <= 16'h0000;
         dout_q     <= 8'h00;
         rdata_q    <= 8'h00;
         wstb_b     <= 1'b1;
         rstb_b     <= 1'b1;
         done       <= 2'b00;
         busy_q     <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         last_grant <= last_grant_nxt;
         gnt        <= gnt_nxt;
         cyc_we     <= cyc_we_nxt;
         addr_q     <= addr_nxt;
         dout_q     <= dout_nxt;
         rdata_q    <= rdata_nxt;
         wstb_b     <= wstb_b_nxt;
         rstb_b     <= rstb_b_nxt;
         done       <= done_nxt;
         busy_q     <= busy_nxt;
      end
   end

   assign bus.done0          = done[0];
   assign bus.done1          = done[1];
   assign bus.rdata          = rdata_q;
   assign bus.busy           = busy_q;
   assign bus.address_bus    = addr_q;
   assign bus.data_bus_out   = dout_q;
   assign bus.write_strobe_b = wstb_b;
   assign bus.read_strobe_b  = rstb_b;
endmodule

// File: tb/tb_zube_bus_sequencer.sv
// Bench for zube_bus_sequencer: a default-timed and a slow-timed instance,
// checked every cycle against a timeline model plus directed literal checks.
module tb_zube_bus_sequencer;
   logic clk = 1'b0;
   logic reset_b = 1'b0;
   always #5 clk = ~clk;

   zube_bus_sequencer_if ifa ();
   zube_bus_sequencer_if ifb ();

   zube_bus_sequencer u_a (.clk(clk), .reset_b(reset_b), .bus(ifa));
   zube_bus_sequencer #(.SETUP_CYCLES(3), .STROBE_CYCLES(5), .HOLD_CYCLES(2))
      u_b (.clk(clk), .reset_b(reset_b), .bus(ifb));

   logic        req_s [2][2];
   logic        we_s  [2][2];
   logic [15:0] addr_s[2][2];
   logic [7:0]  wd_s  [2][2];

   logic        busy_o[2], ws_o[2], rs_o[2];
   logic [1:0]  done_o[2];
   logic [15:0] ab_o[2];
   logic [7:0]  do_o[2], rd_o[2];

   function automatic logic [7:0] periph(input logic [15:0] a);
      return a[7:0] ^ 8'hC2;
   endfunction

   assign ifa.req0 = req_s[0][0]; assign ifa.we0 = we_s[0][0];
   assign ifa.addr0 = addr_s[0][0]; assign ifa.wdata0 = wd_s[0][0];
   assign ifa.req1 = req_s[0][1]; assign ifa.we1 = we_s[0][1];
   assign ifa.addr1 = addr_s[0][1]; assign ifa.wdata1 = wd_s[0][1];
   assign ifb.req0 = req_s[1][0]; assign ifb.we0 = we_s[1][0];
   assign ifb.addr0 = addr_s[1][0]; assign ifb.wdata0 = wd_s[1][0];
   assign ifb.req1 = req_s[1][1]; assign ifb.we1 = we_s[1][1];
   assign ifb.addr1 = addr_s[1][1]; assign ifb.wdata1 = wd_s[1][1];
   assign ifa.data_bus_in = !ifa.read_strobe_b ? periph(ifa.address_bus) : 8'h00;
   assign ifb.data_bus_in = !ifb.read_strobe_b ? periph(ifb.address_bus) : 8'h00;

   assign busy_o[0] = ifa.busy; assign busy_o[1] = ifb.busy;
   assign ws_o[0] = ifa.write_strobe_b; assign ws_o[1] = ifb.write_strobe_b;
   assign rs_o[0] = ifa.read_strobe_b; assign rs_o[1] = ifb.read_strobe_b;
   assign done_o[0] = {ifa.done1, ifa.done0}; assign done_o[1] = {ifb.done1, ifb.done0};
   assign ab_o[0] = ifa.address_bus; assign ab_o[1] = ifb.address_bus;
   assign do_o[0] = ifa.data_bus_out; assign do_o[1] = ifb.data_bus_out;
   assign rd_o[0] = ifa.rdata; assign rd_o[1] = ifb.rdata;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, a, e);
      end
   endtask

   // Model: each access is a fixed timeline measured in edges since its grant.
   int S[2] = '{1, 3};
   int T[2] = '{4, 5};
   int H[2] = '{1, 2};
   bit          act[2];
   int          t[2], g[2], lastg[2];
   logic [15:0] ma[2];
   logic [7:0]  md[2], mr[2];
   logic        mw[2];

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         act[i] = 0; t[i] = 0; g[i] = 0; lastg[i] = 1;
         ma[i] = '0; md[i] = '0; mr[i] = '0; mw[i] = 0;
      end
   endtask

   task automatic model_step(input int i);
      int p;
      if (act[i]) begin
         t[i]++;
         if (t[i] == S[i] + T[i] && !mw[i]) mr[i] = periph(ma[i]);
         if (t[i] == S[i] + T[i] + H[i] + 1) act[i] = 0;
      end else if (req_s[i][0] || req_s[i][1]) begin
         if (req_s[i][0] && req_s[i][1]) p = (lastg[i] == 0) ? 1 : 0;
         else p = req_s[i][1] ? 1 : 0;
         act[i] = 1; t[i] = 0; g[i] = p; lastg[i] = p;
         ma[i] = addr_s[i][p]; md[i] = wd_s[i][p]; mw[i] = we_s[i][p];
      end
   endtask

   task automatic compare(input int i);
      logic on;
      logic [1:0] ed;
      logic [36:0] e, a;
      on = act[i] && t[i] >= S[i] && t[i] < S[i] + T[i];
      ed = (act[i] && t[i] == S[i] + T[i] + H[i]) ? (g[i] == 1 ? 2'b10 : 2'b01) : 2'b00;
      e = {act[i], !(on && mw[i]), !(on && !mw[i]), ed, ma[i], md[i], mr[i]};
      a = {busy_o[i], ws_o[i], rs_o[i], done_o[i], ab_o[i], do_o[i], rd_o[i]};
      chk($sformatf("model_inst%0d busy/ws/rs/done/addr/dout/rdata", i), 64'(a), 64'(e));
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge reset_b);
         if (!reset_b) model_reset();
         else for (int i = 0; i < 2; i++) model_step(i);
         #1;
         for (int i = 0; i < 2; i++) compare(i);
      end
   end

   // Follows one access on instance i until its done pulse, counting cycles.
   task automatic watch(input int i, input bit drop, output int gid, output int wl,
                        output int rl, output int bc, output int fall);
      gid = -1; wl = 0; rl = 0; bc = 0; fall = -1;
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         if (!busy_o[i]) begin
            wl = 0; rl = 0; bc = 0; fall = -1;
         end else begin
            bc++;
            if (!ws_o[i]) wl++;
            if (!rs_o[i]) rl++;
            if ((!ws_o[i] || !rs_o[i]) && fall < 0) fall = bc - 1;
         end
         if (done_o[i] != 2'b00) begin
            gid = done_o[i][1] ? 1 : 0;
            if (drop) req_s[i][gid] = 1'b0;
            return;
         end
      end
      tests++; fails++;
      $display("FAIL watch_inst%0d: no done pulse within 60 cycles", i);
   endtask

   initial begin
      int gid, wl, rl, bc, fall;
      int order[4];
      for (int i = 0; i < 2; i++)
         for (int r = 0; r < 2; r++) begin
            req_s[i][r] = 0; we_s[i][r] = 0; addr_s[i][r] = '0; wd_s[i][r] = '0;
         end
      // both requesters high from reset: write A000 on req0, read A001 on req1
      req_s[0][0] = 1; we_s[0][0] = 1; addr_s[0][0] = 16'hA000; wd_s[0][0] = 8'h5A;
      req_s[0][1] = 1; we_s[0][1] = 0; addr_s[0][1] = 16'hA001; wd_s[0][1] = 8'hFF;
      repeat (3) @(negedge clk);
      chk("reset_busy", 64'(busy_o[0]), 64'd0);
      chk("reset_strobes", 64'({ws_o[0], rs_o[0]}), 64'b11);
      chk("reset_addr", 64'(ab_o[0]), 64'h0);
      chk("reset_rdata", 64'(rd_o[0]), 64'h0);
      reset_b = 1'b1;

      watch(0, 1, gid, wl, rl, bc, fall);
      chk("write_first_grant", 64'(gid), 64'd0);
      chk("write_strobe_cycles", 64'(wl), 64'd4);
      chk("write_no_read_strobe", 64'(rl), 64'd0);
      chk("write_busy_cycles", 64'(bc), 64'd7);
      chk("write_addr_data", 64'({ab_o[0], do_o[0]}), 64'hA0005A);

      watch(0, 1, gid, wl, rl, bc, fall);
      chk("read_second_grant", 64'(gid), 64'd1);
      chk("read_strobe_cycles", 64'(rl), 64'd4);
      chk("read_no_write_strobe", 64'(wl), 64'd0);
      chk("read_rdata", 64'(rd_o[0]), 64'hC3);

      // both held and re-raised: grants must alternate
      req_s[0][0] = 1; req_s[0][1] = 1;
      for (int k = 0; k < 4; k++) begin
         watch(0, 1, gid, wl, rl, bc, fall);
         order[k] = gid;
         @(negedge clk);
         if (k < 3) req_s[0][gid] = 1'b1;
      end
      req_s[0][0] = 0; req_s[0][1] = 0;
      for (int k = 0; k < 4; k++) chk($sformatf("alternate_grant%0d", k), 64'(order[k]), 64'(k % 2));

      // slow timing instance
      req_s[1][0] = 1; we_s[1][0] = 1; addr_s[1][0] = 16'h1234; wd_s[1][0] = 8'h77;
      watch(1, 1, gid, wl, rl, bc, fall);
      chk("slow_busy_cycles", 64'(bc), 64'd11);
      chk("slow_strobe_cycles", 64'(wl), 64'd5);
      chk("slow_strobe_fall", 64'(fall), 64'd3);

      // reset in the second strobe cycle of a write
      req_s[0][0] = 1; we_s[0][0] = 1; addr_s[0][0] = 16'hB000; wd_s[0][0] = 8'h11;
      begin
         int n;
         for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (!ws_o[0]) break;
         end
         chk("reset_test_strobe_seen", 64'(n < 20), 64'd1);
      end
      @(posedge clk); #2;
      reset_b = 1'b0;
      req_s[0][0] = 0;
      #1;
      chk("async_reset_outputs",
          64'({busy_o[0], ws_o[0], rs_o[0], done_o[0], ab_o[0], do_o[0]}), 64'({3'b011, 2'b00, 24'h0}));
      @(negedge clk);
      reset_b = 1'b1;
      begin
         int seen = 0;
         repeat (10) begin
            @(negedge clk);
            if (done_o[0] != 2'b00) seen++;
         end
         chk("no_done_after_reset", 64'(seen), 64'd0);
      end
      req_s[0][0] = 1; we_s[0][0] = 1; addr_s[0][0] = 16'hC000; wd_s[0][0] = 8'h22;
      watch(0, 1, gid, wl, rl, bc, fall);
      chk("post_reset_access", 64'({gid[0], wl[3:0]}), 64'h04);

      // drop req0 after grant, req1 arrives while busy
      @(negedge clk);
      req_s[0][0] = 1; we_s[0][0] = 0; addr_s[0][0] = 16'h0042;
      @(negedge clk);
      req_s[0][0] = 0;
      req_s[0][1] = 1; we_s[0][1] = 1; addr_s[0][1] = 16'h0010; wd_s[0][1] = 8'h99;
      watch(0, 1, gid, wl, rl, bc, fall);
      chk("dropped_req_done", 64'(gid), 64'd0);
      chk("dropped_req_rdata", 64'(rd_o[0]), 64'h80);
      watch(0, 1, gid, wl, rl, bc, fall);
      chk("waiting_req_served", 64'(gid), 64'd1);

      // randomized traffic on both instances, model checked every cycle
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++)
            for (int r = 0; r < 2; r++) begin
               if (done_o[i][r]) req_s[i][r] = 1'b0;
               else if (!req_s[i][r] && $urandom_range(0, 5) == 0) begin
                  req_s[i][r] = 1'b1; we_s[i][r] = 1'($urandom);
                  addr_s[i][r] = 16'($urandom); wd_s[i][r] = 8'($urandom);
               end else if (req_s[i][r] && $urandom_range(0, 19) == 0) begin
                  we_s[i][r] = 1'($urandom);
                  addr_s[i][r] = 16'($urandom); wd_s[i][r] = 8'($urandom);
               end else if (req_s[i][r] && $urandom_range(0, 39) == 0)
                  req_s[i][r] = 1'b0;
            end
      end
      for (int i = 0; i < 2; i++) begin
         req_s[i][0] = 0; req_s[i][1] = 0;
      end
      repeat (30) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
